// File: rtl/probe_rx_sync.sv
// rtl/probe_rx_sync.sv - LFSR probe receiver: chip slicer, self-sync LFSR replica, lock FSM, windowed error count
// Optional build macro: PROBE_RX_STATS_EN adds lifetime chip/error counters with a synchronous clear.
module probe_rx_sync #(
    parameter int                LFSR_W = 10,
    parameter logic [LFSR_W-1:0] TAPS   = 10'h240,
    parameter int                CNT_W  = 16
) (
    input  logic             clk,
    input  logic             arstn,
    input  logic             en,
    input  logic             in_vld,
    input  logic [63:0]      in_data,
    input  logic [CNT_W-1:0] chk_len_min1,
    input  logic [CNT_W-1:0] win_len_min1,
    input  logic [CNT_W-1:0] err_max,
    output logic             locked,
    output logic             lock_pulse,
    output logic             lost_pulse,
    output logic [CNT_W-1:0] err_cnt,
    output logic [1:0]       state_o
`ifdef PROBE_RX_STATS_EN
    ,
    input  logic             stats_clr,
    output logic [31:0]      tot_chips,
    output logic [31:0]      tot_errs
`endif
);

    localparam int FILL_W = $clog2(LFSR_W + 1);
    localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(LFSR_W);

    typedef enum logic [1:0] {
        ST_HUNT  = 2'd0,
        ST_CHECK = 2'd1,
        ST_LOCK  = 2'd2
    } state_t;

    state_t              r_state, w_state_nxt;
    logic [LFSR_W-1:0]   r_lfsr, w_lfsr_nxt;
    logic [FILL_W-1:0]   r_fill, w_fill_nxt;
    logic [CNT_W-1:0]    r_match, w_match_nxt;
    logic [CNT_W-1:0]    r_win, w_win_nxt;
    logic [CNT_W-1:0]    r_err_win, w_err_win_nxt;
    logic [CNT_W-1:0]    r_err_cnt, w_err_cnt_nxt;
    logic                r_lock_pulse, w_lock_pulse_nxt;
    logic                r_lost_pulse, w_lost_pulse_nxt;
    logic                r_locked;
    logic                r_chip, r_chip_vld;

    logic signed [17:0]  w_sum;
    logic                w_neg;
    logic                w_pred, w_mis;
    logic [LFSR_W-1:0]   w_lfsr_chip;
    logic [FILL_W-1:0]   w_fill_inc;
    logic [CNT_W-1:0]    w_err_win_upd;

    // Chip decision: sign of the sum of the four samples in the beat
    assign w_sum = 18'(signed'(in_data[15:0]))  + 18'(signed'(in_data[31:16]))
                 + 18'(signed'(in_data[47:32])) + 18'(signed'(in_data[63:48]));
    assign w_neg = (w_sum < 18'sd0);

    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            r_chip     <= 1'b0;
            r_chip_vld <= 1'b0;
        end else begin
            r_chip_vld <= in_vld;
            if (in_vld) begin
                r_chip <= w_neg;
            end
        end
    end

    assign w_pred        = ^(r_lfsr & TAPS);
    assign w_mis         = r_chip ^ w_pred;
    assign w_lfsr_chip   = {r_lfsr[LFSR_W-2:0], r_chip};
    assign w_fill_inc    = (r_fill == FILL_FULL) ? r_fill : r_fill + 1'b1;
    assign w_err_win_upd = (w_mis && !(&r_err_win)) ? r_err_win + 1'b1 : r_err_win;

    always_comb begin
        w_state_nxt      = r_state;
        w_lfsr_nxt       = r_lfsr;
        w_fill_nxt       = r_fill;
        w_match_nxt      = r_match;
        w_win_nxt        = r_win;
        w_err_win_nxt    = r_err_win;
        w_err_cnt_nxt    = r_err_cnt;
        w_lock_pulse_nxt = 1'b0;
        w_lost_pulse_nxt = 1'b0;
        if (!en) begin
            w_state_nxt      = ST_HUNT;
            w_fill_nxt       = '0;
            w_match_nxt      = '0;
            w_win_nxt        = '0;
            w_err_win_nxt    = '0;
            w_lost_pulse_nxt = (r_state == ST_LOCK);
        end else if (r_chip_vld) begin
            case (r_state)
                ST_HUNT: begin
                    w_lfsr_nxt = w_lfsr_chip;
                    w_fill_nxt = w_fill_inc;
                    // An all-zero register would predict zeros forever, so it never qualifies
                    if (w_fill_inc == FILL_FULL && w_lfsr_chip != '0) begin
                        w_state_nxt = ST_CHECK;
                        w_match_nxt = '0;
                    end
                end
                ST_CHECK: begin
                    if (!w_mis) begin
                        w_lfsr_nxt = w_lfsr_chip;
                        if (r_match == chk_len_min1) begin
                            w_state_nxt      = ST_LOCK;
                            w_lock_pulse_nxt = 1'b1;
                            w_win_nxt        = '0;
                            w_err_win_nxt    = '0;
                        end else begin
                            w_match_nxt = r_match + 1'b1;
                        end
                    end else begin
                        w_state_nxt = ST_HUNT;
                        w_fill_nxt  = '0;
                    end
                end
                ST_LOCK: begin
                    // Flywheel: the replica runs on its own prediction, received chips are only compared
                    w_lfsr_nxt    = {r_lfsr[LFSR_W-2:0], w_pred};
                    w_err_win_nxt = w_err_win_upd;
                    if (w_err_win_upd > err_max) begin
                        w_state_nxt      = ST_HUNT;
                        w_fill_nxt       = '0;
                        w_lost_pulse_nxt = 1'b1;
                        w_err_cnt_nxt    = w_err_win_upd;
                        w_win_nxt        = '0;
                        w_err_win_nxt    = '0;
                    end else if (r_win == win_len_min1) begin
                        w_err_cnt_nxt = w_err_win_upd;
                        w_win_nxt     = '0;
                        w_err_win_nxt = '0;
                    end else begin
                        w_win_nxt = r_win + 1'b1;
                    end
                end
                default: begin
                    w_state_nxt = ST_HUNT;
                    w_fill_nxt  = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            r_state      <= ST_HUNT;
            r_lfsr       <= '0;
            r_fill       <= '0;
            r_match      <= '0;
            r_win        <= '0;
            r_err_win    <= '0;
            r_err_cnt    <= '0;
            r_lock_pulse <= 1'b0;
            r_lost_pulse <= 1'b0;
            r_locked     <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_lfsr       <= w_lfsr_nxt;
            r_fill       <= w_fill_nxt;
            r_match      <= w_match_nxt;
            r_win        <= w_win_nxt;
            r_err_win    <= w_err_win_nxt;
            r_err_cnt    <= w_err_cnt_nxt;
            r_lock_pulse <= w_lock_pulse_nxt;
            r_lost_pulse <= w_lost_pulse_nxt;
            r_locked     <= (w_state_nxt == ST_LOCK);
        end
    end

    assign locked     = r_locked;
    assign lock_pulse = r_lock_pulse;
    assign lost_pulse = r_lost_pulse;
    assign err_cnt    = r_err_cnt;
    assign state_o    = r_state;

`ifdef PROBE_RX_STATS_EN
    logic [31:0] r_tot_chips, r_tot_errs;

    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            r_tot_chips <= '0;
            r_tot_errs  <= '0;
        end else if (stats_clr) begin
            r_tot_chips <= '0;
            r_tot_errs  <= '0;
        end else if (en && r_chip_vld && r_state == ST_LOCK) begin
            if (!(&r_tot_chips)) begin
                r_tot_chips <= r_tot_chips + 1'b1;
            end
            if (w_mis && !(&r_tot_errs)) begin
                r_tot_errs <= r_tot_errs + 1'b1;
            end
        end
    end

    assign tot_chips = r_tot_chips;
    assign tot_errs  = r_tot_errs;
`endif

endmodule

// File: tb/tb_probe_rx_sync.sv
// tb/tb_probe_rx_sync.sv - directed bench for probe_rx_sync: lock timing, error windows, zero headers, gaps, enable drop
module tb_probe_rx_sync;

    localparam logic [9:0] TAPS = 10'h240;

    logic        clk = 1'b0;
    logic        arstn;
    logic        en;
    logic        in_vld;
    logic [63:0] in_data;
    logic [15:0] chk_len_min1;
    logic [15:0] win_len_min1;
    logic [15:0] err_max;
    logic        locked;
    logic        lock_pulse;
    logic        lost_pulse;
    logic [15:0] err_cnt;
    logic [1:0]  state_o;
`ifdef PROBE_RX_STATS_EN
    logic        stats_clr;
    logic [31:0] tot_chips;
    logic [31:0] tot_errs;
`endif

    probe_rx_sync dut (
        .clk          (clk),
        .arstn        (arstn),
        .en           (en),
        .in_vld       (in_vld),
        .in_data      (in_data),
        .chk_len_min1 (chk_len_min1),
        .win_len_min1 (win_len_min1),
        .err_max      (err_max),
        .locked       (locked),
        .lock_pulse   (lock_pulse),
        .lost_pulse   (lost_pulse),
        .err_cnt      (err_cnt),
        .state_o      (state_o)
`ifdef PROBE_RX_STATS_EN
        ,
        .stats_clr    (stats_clr),
        .tot_chips    (tot_chips),
        .tot_errs     (tot_errs)
`endif
    );

    always #5 clk = ~clk;

    int         n_checks = 0;
    int         n_fail   = 0;
    int         cyc      = 0;
    int         beats, first_cyc, lock_cyc, lock_beats, lost_cyc, lost_beats;
    logic [9:0] tx_s;
    logic [1:0] prev_state;
    bit         saw_c2h, left_hunt;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp_v);
        end
    endtask

    task automatic clear_trk();
        lock_cyc   = -1;
        lock_beats = -1;
        lost_cyc   = -1;
        lost_beats = -1;
        saw_c2h    = 1'b0;
        left_hunt  = 1'b0;
        prev_state = 2'd0;
    endtask

    // One clock; outputs are observed 1 ns after the edge
    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        if (lock_pulse && lock_cyc < 0) begin
            lock_cyc   = cyc;
            lock_beats = beats;
        end
        if (lost_pulse && lost_cyc < 0) begin
            lost_cyc   = cyc;
            lost_beats = beats;
        end
        if (prev_state == 2'd1 && state_o == 2'd0) saw_c2h = 1'b1;
        if (state_o != 2'd0) left_hunt = 1'b1;
        prev_state = state_o;
    endtask

    task automatic put_chip(input logic b);
        logic [15:0] s;
        s = b ? 16'hFC18 : 16'h03E8;
        in_data = {s, s, s, s};
    endtask

    // Sends the next transmitter chip (optionally inverted), optionally followed by one idle cycle
    task automatic send(input bit flip, input bit gap);
        logic c;
        c    = ^(tx_s & TAPS);
        tx_s = {tx_s[8:0], c};
        put_chip(c ^ flip);
        in_vld = 1'b1;
        beats++;
        if (beats == 1) first_cyc = cyc + 1;
        tick();
        if (gap) begin
            in_vld = 1'b0;
            tick();
        end
    endtask

    task automatic do_reset();
        arstn   = 1'b0;
        en      = 1'b0;
        in_vld  = 1'b0;
        in_data = '0;
        repeat (3) tick();
        check("rst_locked", {31'd0, locked}, 32'd0);
        check("rst_lock_pulse", {31'd0, lock_pulse}, 32'd0);
        check("rst_lost_pulse", {31'd0, lost_pulse}, 32'd0);
        check("rst_err_cnt", {16'd0, err_cnt}, 32'd0);
        check("rst_state", {30'd0, state_o}, 32'd0);
        arstn = 1'b1;
        en    = 1'b1;
        tx_s  = 10'h001;
        beats = 0;
        first_cyc = 0;
        clear_trk();
    endtask

    function automatic bit flip_a(input int idx);
        return (idx == 40 || idx == 60 || idx == 80);
    endfunction

    function automatic bit flip_b(input int idx);
        return (idx == 140 || idx == 150 || idx == 160 || idx == 170);
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        chk_len_min1 = 16'd15;
        win_len_min1 = 16'd99;
        err_max      = 16'd3;
`ifdef PROBE_RX_STATS_EN
        stats_clr    = 1'b0;
`endif
        do_reset();

        // Clean PRBS, continuous beats: 26 chips to lock, pulse one processing edge later
        while (beats < 30) send(1'b0, 1'b0);
        check("t2_lock_latency", 32'(lock_cyc - first_cyc), 32'd26);
        check("t2_locked", {31'd0, locked}, 32'd1);
        check("t2_state", {30'd0, state_o}, 32'd2);
        check("t2_pulse_width", {31'd0, lock_pulse}, 32'd0);

        // First window (chips 26..125) gets 3 flips, second window 4 flips
        while (beats < 121) send(flip_a(beats), 1'b0);
        check("t3_err_before_end", {16'd0, err_cnt}, 32'd0);
        while (beats < 131) send(flip_a(beats), 1'b0);
        check("t3_err_win1", {16'd0, err_cnt}, 32'd3);
        check("t3_locked_win1", {31'd0, locked}, 32'd1);
        while (beats < 176) send(flip_b(beats), 1'b0);
        check("t3_lost_at", 32'(lost_beats), 32'd172);
        check("t3_err_lost", {16'd0, err_cnt}, 32'd4);
        check("t3_unlocked", {31'd0, locked}, 32'd0);

        // Refill after loss: CHECK after chip 180, lock on chip 196
        clear_trk();
        while (lock_cyc < 0 && beats < 300) send(1'b0, 1'b0);
        check("t3_relock_at", 32'(lock_beats), 32'd198);

        // Asynchronous reset while locked
        @(posedge clk);
        #3;
        arstn = 1'b0;
        #1;
        check("t1_async_locked", {31'd0, locked}, 32'd0);
        check("t1_async_state", {30'd0, state_o}, 32'd0);
        check("t1_async_err", {16'd0, err_cnt}, 32'd0);

        // All-zero headers never qualify
        do_reset();
        in_data = {4{16'h01F4}};
        for (int i = 0; i < 1000; i++) begin
            in_vld = 1'b1;
            beats++;
            tick();
        end
        check("t4_left_hunt", {31'd0, left_hunt}, 32'd0);
        check("t4_locked", {31'd0, locked}, 32'd0);

        // Alternating valid: same chip count to lock
        do_reset();
        while (lock_cyc < 0 && beats < 60) send(1'b0, 1'b1);
        check("t5_lock_beats", 32'(lock_beats), 32'd26);
        check("t5_lock_cycles", 32'(lock_cyc - first_cyc), 32'd51);

        // Mismatch at chip 15 (inside CHECK) then relock on chip 41
        do_reset();
        while (lock_cyc < 0 && beats < 100) send(beats == 15, 1'b1);
        check("t5_check_to_hunt", {31'd0, saw_c2h}, 32'd1);
        check("t5_relock_beats", 32'(lock_beats), 32'd42);

        // Enable dropped for one cycle while locked
        en     = 1'b0;
        in_vld = 1'b0;
        tick();
        check("t6_lost_pulse", {31'd0, lost_pulse}, 32'd1);
        check("t6_state", {30'd0, state_o}, 32'd0);
        check("t6_locked", {31'd0, locked}, 32'd0);
        en = 1'b1;
        tick();
        check("t6_pulse_width", {31'd0, lost_pulse}, 32'd0);
        clear_trk();
        while (lock_cyc < 0 && beats < 200) send(1'b0, 1'b0);
        check("t6_relock", {31'd0, (lock_cyc >= 0)}, 32'd1);
        check("t6_locked_again", {31'd0, locked}, 32'd1);
`ifdef PROBE_RX_STATS_EN
        for (int i = 0; i < 10; i++) send(i == 4, 1'b0);
        check("t6_tot_chips_nz", {31'd0, (tot_chips != 0)}, 32'd1);
        check("t6_tot_errs", tot_errs, 32'd1);
        stats_clr = 1'b1;
        tick();
        stats_clr = 1'b0;
        check("t6_clr_chips", tot_chips, 32'd0);
        check("t6_clr_errs", tot_errs, 32'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
